// File: rtl/md_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer: function codes,
// FSM state encoding, iteration counts and small decode helpers.
package md_pkg;

  localparam logic [5:0] FUNC_MFHI  = 6'h10;
  localparam logic [5:0] FUNC_MTHI  = 6'h11;
  localparam logic [5:0] FUNC_MFLO  = 6'h12;
  localparam logic [5:0] FUNC_MTLO  = 6'h13;
  localparam logic [5:0] FUNC_MULT  = 6'h18;
  localparam logic [5:0] FUNC_MULTU = 6'h19;
  localparam logic [5:0] FUNC_DIV   = 6'h1A;
  localparam logic [5:0] FUNC_DIVU  = 6'h1B;

  localparam int MUL_CYCLES = 4;
  localparam int DIV_CYCLES = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MUL_RUN = 2'd1,
    DIV_RUN = 2'd2,
    DONE    = 2'd3
  } md_state_t;

  function automatic logic is_muldiv_func(input logic [5:0] f);
    return (f == FUNC_MULT) || (f == FUNC_MULTU) || (f == FUNC_DIV) || (f == FUNC_DIVU);
  endfunction

  function automatic logic is_move_func(input logic [5:0] f);
    return (f == FUNC_MTHI) || (f == FUNC_MTLO);
  endfunction

endpackage

// File: rtl/md_step_counter.sv
// 5-bit loadable down-counter; saturates at zero so the final step count
// stays visible through DONE and IDLE.
module md_step_counter (
  input  logic       clk,
  input  logic       nrst,
  input  logic       load_i,
  input  logic [4:0] load_val_i,
  input  logic       en_i,
  output logic [4:0] count_o,
  output logic       zero_o
);

  logic [4:0] count_q;
  logic [4:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (en_i && (count_q != 5'd0)) begin
      count_d = count_q - 5'd1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      count_q <= 5'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign zero_o  = (count_q == 5'd0);

endmodule

// File: rtl/md_sequencer.sv
// Control sequencer for the iterative multiply/divide unit: accepts HI/LO-class
// instructions from EX, runs the step sequence and stalls dependent instructions.
module md_sequencer
  import md_pkg::*;
(
  input  logic       clk,
  input  logic       nrst,
  input  logic       MulDivOp,
  input  logic [5:0] Func,
  input  logic       Hold,
  input  logic       Flush,
  output logic       Start,
  output logic       StepEn,
  output logic [4:0] StepCount,
  output logic       IsDiv,
  output logic       IsSigned,
  output logic       AccEn,
  output logic       AccSrcMove,
  output logic       Busy,
  output logic       StallEx
);

  localparam logic [4:0] MUL_LOAD = 5'(MUL_CYCLES - 1);
  localparam logic [4:0] DIV_LOAD = 5'(DIV_CYCLES - 1);

  md_state_t  state_q;
  md_state_t  state_d;
  logic       is_div_q;
  logic       is_signed_q;
  logic       issue_ok;
  logic       accept;
  logic       move_acc;
  logic       step_en;
  logic       cnt_load;
  logic [4:0] cnt_load_val;
  logic [4:0] cnt_value;
  logic       cnt_zero;

  // nrst is folded in so the combinational strobes stay low while reset is held.
  assign issue_ok = nrst && MulDivOp && !Hold && !Flush && (state_q == IDLE);
  assign accept   = issue_ok && is_muldiv_func(Func);
  assign move_acc = issue_ok && is_move_func(Func);

  always_comb begin
    state_d      = state_q;
    step_en      = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = MUL_LOAD;
    AccEn        = 1'b0;
    AccSrcMove   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_load     = 1'b1;
          cnt_load_val = Func[1] ? DIV_LOAD : MUL_LOAD;
          state_d      = Func[1] ? DIV_RUN : MUL_RUN;
        end else if (move_acc) begin
          AccEn      = 1'b1;
          AccSrcMove = 1'b1;
        end
      end
      MUL_RUN, DIV_RUN: begin
        step_en = 1'b1;
        if (cnt_zero) begin
          state_d = DONE;
        end
      end
      DONE: begin
        AccEn   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Func[1] separates DIV* from MULT*; Func[0] set marks the unsigned variant.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= IDLE;
      is_div_q    <= 1'b0;
      is_signed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        is_div_q    <= Func[1];
        is_signed_q <= ~Func[0];
      end
    end
  end

  md_step_counter u_step_counter (
    .clk        (clk),
    .nrst       (nrst),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .en_i       (step_en),
    .count_o    (cnt_value),
    .zero_o     (cnt_zero)
  );

  assign Start     = accept;
  assign StepEn    = step_en;
  assign StepCount = cnt_value;
  assign IsDiv     = is_div_q;
  assign IsSigned  = is_signed_q;
  assign Busy      = (state_q != IDLE);
  assign StallEx   = MulDivOp && (state_q != IDLE);

endmodule

// File: tb/tb_md_sequencer.sv
// Directed-vector bench for md_sequencer with hand-computed per-cycle expectations.
module tb_md_sequencer;
  import md_pkg::*;

  logic       clk;
  logic       nrst;
  logic       MulDivOp;
  logic [5:0] Func;
  logic       Hold;
  logic       Flush;
  logic       Start;
  logic       StepEn;
  logic [4:0] StepCount;
  logic       IsDiv;
  logic       IsSigned;
  logic       AccEn;
  logic       AccSrcMove;
  logic       Busy;
  logic       StallEx;

  int tests_run = 0;
  int tests_failed = 0;

  md_sequencer dut (
    .clk        (clk),
    .nrst       (nrst),
    .MulDivOp   (MulDivOp),
    .Func       (Func),
    .Hold       (Hold),
    .Flush      (Flush),
    .Start      (Start),
    .StepEn     (StepEn),
    .StepCount  (StepCount),
    .IsDiv      (IsDiv),
    .IsSigned   (IsSigned),
    .AccEn      (AccEn),
    .AccSrcMove (AccSrcMove),
    .Busy       (Busy),
    .StallEx    (StallEx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cyc(input string tag, input logic s, input logic se, input logic [4:0] sc,
                         input logic ae, input logic as, input logic b, input logic st);
    chk({tag, ".Start"},      {31'd0, Start},      {31'd0, s});
    chk({tag, ".StepEn"},     {31'd0, StepEn},     {31'd0, se});
    chk({tag, ".StepCount"},  {27'd0, StepCount},  {27'd0, sc});
    chk({tag, ".AccEn"},      {31'd0, AccEn},      {31'd0, ae});
    chk({tag, ".AccSrcMove"}, {31'd0, AccSrcMove}, {31'd0, as});
    chk({tag, ".Busy"},       {31'd0, Busy},       {31'd0, b});
    chk({tag, ".StallEx"},    {31'd0, StallEx},    {31'd0, st});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called in the accept cycle c0 after Start was checked; ends inside c6 (IDLE).
  task automatic mul_tail(input string pfx, input logic hf);
    step();
    MulDivOp = 1'b0;
    Hold     = hf;
    Flush    = hf;
    for (int i = 1; i <= 4; i++) begin
      #1;
      chk_cyc($sformatf("%s_c%0d", pfx, i), 1'b0, 1'b1, 5'(4 - i), 1'b0, 1'b0, 1'b1, 1'b0);
      step();
    end
    Hold  = 1'b0;
    Flush = 1'b0;
    #1;
    chk_cyc({pfx, "_c5"}, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    chk_cyc({pfx, "_c6"}, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    nrst     = 1'b0;
    MulDivOp = 1'b1;
    Func     = FUNC_MULT;
    Hold     = 1'b0;
    Flush    = 1'b0;

    // Reset holds every output low even with an acceptable instruction present
    #2;
    chk_cyc("rst_mult", 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    Func = FUNC_MTHI;
    #1;
    chk_cyc("rst_mthi", 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_isdiv", {31'd0, IsDiv}, 32'd0);
    chk("rst_issigned", {31'd0, IsSigned}, 32'd0);
    MulDivOp = 1'b0;
    step();
    step();
    nrst = 1'b1;
    #1;
    chk_cyc("idle", 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();

    // MULT: Start c0, StepEn c1-c4 (3..0), AccEn c5, IDLE c6
    MulDivOp = 1'b1;
    Func     = FUNC_MULT;
    #1;
    chk_cyc("mult_c0", 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk("mult_isdiv", {31'd0, IsDiv}, 32'd0);
    chk("mult_issigned", {31'd0, IsSigned}, 32'd1);
    MulDivOp = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      #1;
      chk_cyc($sformatf("mult_c%0d", c), 1'b0, 1'b1, 5'(4 - c), 1'b0, 1'b0, 1'b1, 1'b0);
      step();
    end
    chk_cyc("mult_c5", 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    chk_cyc("mult_c6", 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();

    // DIVU at c0, MFLO waiting from c3; stalled through DONE at c33
    MulDivOp = 1'b1;
    Func     = FUNC_DIVU;
    #1;
    chk_cyc("divu_c0", 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    MulDivOp = 1'b0;
    for (int c = 1; c <= 33; c++) begin
      if (c == 3) begin
        MulDivOp = 1'b1;
        Func     = FUNC_MFLO;
      end
      #1;
      chk_cyc($sformatf("divu_c%0d", c), 1'b0, (c <= 32), (c <= 32) ? 5'(32 - c) : 5'd0,
              (c == 33), 1'b0, 1'b1, (c >= 3));
      if (c == 1) begin
        chk("divu_isdiv", {31'd0, IsDiv}, 32'd1);
        chk("divu_issigned", {31'd0, IsSigned}, 32'd0);
      end
      step();
    end
    chk_cyc("divu_c34_mflo", 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    MulDivOp = 1'b0;
    step();

    // MTHI/MTLO in IDLE: immediate move write, no state change; Hold suppresses it
    MulDivOp = 1'b1;
    Func     = FUNC_MTHI;
    #1;
    chk_cyc("mthi", 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    Func = FUNC_MTLO;
    #1;
    chk_cyc("mtlo", 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    Hold = 1'b1;
    #1;
    chk_cyc("mtlo_hold", 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    Hold = 1'b0;
    step();

    // Flush / Hold block acceptance; state must stay IDLE
    Func  = FUNC_MULT;
    Flush = 1'b1;
    #1;
    chk_cyc("mult_flush", 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    Flush = 1'b0;
    Hold  = 1'b1;
    #1;
    chk_cyc("mult_hold", 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    Hold = 1'b0;
    Func = 6'h20;
    #1;
    chk_cyc("bad_func", 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    Func = FUNC_MFHI;
    #1;
    chk_cyc("mfhi_idle", 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    MulDivOp = 1'b0;
    Func     = FUNC_MULT;
    #1;
    chk_cyc("not_op", 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();

    // MULTU with Hold/Flush raised during the run: sequence unchanged
    MulDivOp = 1'b1;
    Func     = FUNC_MULTU;
    #1;
    chk_cyc("multu_c0", 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    mul_tail("multu_hf", 1'b1);
    step();

    // DIV with reset pulsed at c10: abort, no AccEn, then a full MULT
    MulDivOp = 1'b1;
    Func     = FUNC_DIV;
    #1;
    chk_cyc("div_c0", 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    MulDivOp = 1'b0;
    for (int c = 1; c < 10; c++) step();
    chk_cyc("div_c10", 1'b0, 1'b1, 5'd22, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("div_issigned", {31'd0, IsSigned}, 32'd1);
    nrst = 1'b0;
    #1;
    chk_cyc("div_rst", 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("div_rst_isdiv", {31'd0, IsDiv}, 32'd0);
    step();
    chk_cyc("div_rst_hold", 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    nrst = 1'b1;
    #1;
    chk_cyc("div_rel", 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk_cyc("div_rel_next", 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    MulDivOp = 1'b1;
    Func     = FUNC_MULT;
    #1;
    chk_cyc("post_rst_c0", 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    mul_tail("post_rst", 1'b0);
    step();

    // Back-to-back MULT: second stalled through DONE, accepted at c6
    MulDivOp = 1'b1;
    Func     = FUNC_MULT;
    #1;
    chk_cyc("b2b_c0", 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    for (int c = 1; c <= 5; c++) begin
      chk_cyc($sformatf("b2b_c%0d", c), 1'b0, (c <= 4), (c <= 4) ? 5'(4 - c) : 5'd0,
              (c == 5), 1'b0, 1'b1, 1'b1);
      step();
    end
    chk_cyc("b2b_c6", 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    MulDivOp = 1'b0;
    #1;
    chk_cyc("b2b_c7", 1'b0, 1'b1, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int c = 0; c < 5; c++) step();
    chk_cyc("b2b_end", 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
